// File: rtl/cube_color_updater.sv
// Write side of the pyramid colour interface: turns Qbert landings into per-cube
// top-colour updates, tracks cubes remaining and reports score/level events.
module cube_color_updater #(
  parameter int N_CUBE = 28,
  parameter int CNT_W  = 5
) (
  input  logic              CLK_33,
  input  logic              reset,
  input  logic              e_level_start,
  input  logic [1:0]        e_color_mode,
  input  logic              e_pause_qb,
  input  logic [N_CUBE-1:0] position_qb,
  input  logic              done_move_qb,
  output logic [N_CUBE-1:0] e_color_state,
  output logic [CNT_W-1:0]  cubes_left,
  output logic              score_pulse,
  output logic              off_map,
  output logic              bad_pos,
  output logic              level_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    UPDATE = 3'd2,
    COUNT  = 3'd3,
    WIN    = 3'd4
  } state_t;

  localparam logic [1:0]       MODE_SET_ONCE = 2'd0;
  localparam logic [1:0]       MODE_TWO_HIT  = 2'd1;
  localparam logic [1:0]       MODE_TOGGLE   = 2'd2;
  localparam logic [CNT_W-1:0] N_FULL        = CNT_W'(N_CUBE);

  function automatic logic [CNT_W-1:0] popcount(input logic [N_CUBE-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CUBE; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  state_t              state;
  logic [N_CUBE-1:0]   color;
  logic [N_CUBE-1:0]   hit;
  logic [1:0]          mode;
  logic [CNT_W-1:0]    cubes_left_q;
  logic                level_done_q;
  logic                done_prev;
  logic [N_CUBE-1:0]   pos_q;
  logic                pos_ok;
  logic                score_q;
  logic                off_map_q;
  logic                bad_pos_q;

  logic                landing;
  logic [CNT_W-1:0]    pos_cnt;
  logic [CNT_W-1:0]    left_next;
  logic                sel_color;
  logic                sel_hit;
  logic                would_score;
  logic [N_CUBE-1:0]   color_next;

  assign landing   = done_move_qb & ~done_prev & ~e_pause_qb & (state == IDLE);
  assign pos_cnt   = popcount(position_qb);
  assign left_next = N_FULL - popcount(color);
  assign sel_color = |(color & pos_q);
  assign sel_hit   = |(hit & pos_q);

  // Score is decided one cycle ahead of the colour write so it lines up with UPDATE.
  always_comb begin
    would_score = 1'b0;
    color_next  = color;
    case (mode)
      MODE_TWO_HIT: begin
        would_score = ~(sel_hit & sel_color);
        color_next  = sel_hit ? (color | pos_q) : color;
      end
      MODE_TOGGLE: begin
        would_score = ~sel_color;
        color_next  = color ^ pos_q;
      end
      default: begin
        would_score = ~sel_color;
        color_next  = color | pos_q;
      end
    endcase
  end

  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      color        <= '0;
      hit          <= '0;
      mode         <= MODE_SET_ONCE;
      cubes_left_q <= N_FULL;
      level_done_q <= 1'b0;
      done_prev    <= 1'b1;
      pos_q        <= '0;
      pos_ok       <= 1'b0;
      score_q      <= 1'b0;
      off_map_q    <= 1'b0;
      bad_pos_q    <= 1'b0;
    end else begin
      done_prev <= done_move_qb;
      score_q   <= 1'b0;
      off_map_q <= 1'b0;
      bad_pos_q <= 1'b0;
      if (e_level_start) begin
        state        <= IDLE;
        color        <= '0;
        hit          <= '0;
        mode         <= (e_color_mode == 2'd3) ? MODE_SET_ONCE : e_color_mode;
        cubes_left_q <= N_FULL;
        level_done_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (landing) begin
              pos_q     <= position_qb;
              pos_ok    <= (pos_cnt == CNT_W'(1));
              off_map_q <= (pos_cnt == '0);
              bad_pos_q <= (pos_cnt > CNT_W'(1));
              state     <= CHECK;
            end
          end
          CHECK: begin
            if (pos_ok) begin
              score_q <= would_score;
              state   <= UPDATE;
            end else begin
              state <= IDLE;
            end
          end
          UPDATE: begin
            color <= color_next;
            if (mode == MODE_TWO_HIT) hit <= hit | pos_q;
            state <= COUNT;
          end
          COUNT: begin
            cubes_left_q <= left_next;
            if (left_next == '0) begin
              level_done_q <= 1'b1;
              state        <= WIN;
            end else begin
              state <= IDLE;
            end
          end
          WIN: state <= WIN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A level start kills any pulse already registered for the current cycle.
  assign score_pulse   = score_q & ~e_level_start;
  assign off_map       = off_map_q & ~e_level_start;
  assign bad_pos       = bad_pos_q & ~e_level_start;
  assign e_color_state = color;
  assign cubes_left    = cubes_left_q;
  assign level_done    = level_done_q;
  assign busy          = (state == CHECK) | (state == UPDATE) | (state == COUNT);

endmodule

// File: tb/tb_cube_color_updater.sv
// Bench for cube_color_updater: table of landings with queued expectations,
// plus hand sequences for full level, level-start collisions and async reset.
module tb_cube_color_updater;

  localparam int N = 28;
  localparam int C = 5;

  typedef struct packed {
    logic         score;
    logic         off;
    logic         bad;
    logic [3:0]   busy;
    logic [N-1:0] color;
    logic [C-1:0] left;
    logic         done;
  } exp_t;
  localparam int W = $bits(exp_t);

  typedef struct {
    logic         start;
    logic [1:0]   mode;
    logic         pause;
    logic [N-1:0] pos;
    exp_t         exp;
  } vec_t;

  logic         CLK_33 = 1'b0;
  logic         reset;
  logic         e_level_start;
  logic [1:0]   e_color_mode;
  logic         e_pause_qb;
  logic [N-1:0] position_qb;
  logic         done_move_qb;
  logic [N-1:0] e_color_state;
  logic [C-1:0] cubes_left;
  logic         score_pulse, off_map, bad_pos, level_done, busy;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[11];

  cube_color_updater #(.N_CUBE(N), .CNT_W(C)) dut (
    .CLK_33(CLK_33), .reset(reset), .e_level_start(e_level_start),
    .e_color_mode(e_color_mode), .e_pause_qb(e_pause_qb), .position_qb(position_qb),
    .done_move_qb(done_move_qb), .e_color_state(e_color_state), .cubes_left(cubes_left),
    .score_pulse(score_pulse), .off_map(off_map), .bad_pos(bad_pos),
    .level_done(level_done), .busy(busy)
  );

  always #5 CLK_33 = ~CLK_33;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic o, input logic b, input logic [3:0] bz,
                              input logic [N-1:0] col, input logic [C-1:0] l, input logic d);
    exp_t e;
    e.score = s; e.off = o; e.bad = b; e.busy = bz; e.color = col; e.left = l; e.done = d;
    return e;
  endfunction

  task automatic start_level(input logic [1:0] mode);
    @(negedge CLK_33);
    e_level_start = 1'b1;
    e_color_mode  = mode;
    @(negedge CLK_33);
    e_level_start = 1'b0;
  endtask

  // Drives one done_move rising edge and compares t+1..t+4 against the queue head.
  task automatic land(input logic [N-1:0] pos, input logic pause);
    exp_t e;
    logic [3:0] bz;
    logic s_t2, s_other, o1, b1, dn;
    logic [N-1:0] col;
    logic [C-1:0] l;
    @(negedge CLK_33);
    position_qb = pos; e_pause_qb = pause; done_move_qb = 1'b1;
    @(negedge CLK_33);
    o1 = off_map; b1 = bad_pos; bz[3] = busy; s_other = score_pulse; done_move_qb = 1'b0;
    @(negedge CLK_33);
    bz[2] = busy; s_t2 = score_pulse;
    @(negedge CLK_33);
    bz[1] = busy; col = e_color_state; s_other = s_other | score_pulse;
    @(negedge CLK_33);
    bz[0] = busy; l = cubes_left; dn = level_done; s_other = s_other | score_pulse;
    e_pause_qb = 1'b0;
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check("score_t2", 64'(s_t2), 64'(e.score));
      check("score_other_cycles", 64'(s_other), 64'd0);
      check("off_map_t1", 64'(o1), 64'(e.off));
      check("bad_pos_t1", 64'(b1), 64'(e.bad));
      check("busy_t1_t4", 64'(bz), 64'(e.busy));
      check("color_t3", 64'(col), 64'(e.color));
      check("cubes_left_t4", 64'(l), 64'(e.left));
      check("level_done_t4", 64'(dn), 64'(e.done));
    end
  endtask

  initial begin
    logic [N:0] mask;
    logic any_busy, any_score;

    vecs[0]  = '{1'b1, 2'd0, 1'b0, 28'h0000020, mk(1, 0, 0, 4'b1110, 28'h0000020, 5'd27, 0)};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 28'h0000001, mk(1, 0, 0, 4'b1110, 28'h0000000, 5'd28, 0)};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 28'h0000001, mk(1, 0, 0, 4'b1110, 28'h0000001, 5'd27, 0)};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 28'h0000001, mk(0, 0, 0, 4'b1110, 28'h0000001, 5'd27, 0)};
    vecs[4]  = '{1'b1, 2'd2, 1'b0, 28'h0000008, mk(1, 0, 0, 4'b1110, 28'h0000008, 5'd27, 0)};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 28'h0000008, mk(0, 0, 0, 4'b1110, 28'h0000000, 5'd28, 0)};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 28'h0000000, mk(0, 1, 0, 4'b1000, 28'h0000000, 5'd28, 0)};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 28'h0000003, mk(0, 0, 1, 4'b1000, 28'h0000000, 5'd28, 0)};
    vecs[8]  = '{1'b0, 2'd2, 1'b1, 28'h0000008, mk(0, 0, 0, 4'b0000, 28'h0000000, 5'd28, 0)};
    vecs[9]  = '{1'b1, 2'd3, 1'b0, 28'h8000000, mk(1, 0, 0, 4'b1110, 28'h8000000, 5'd27, 0)};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 28'h8000000, mk(0, 0, 0, 4'b1110, 28'h8000000, 5'd27, 0)};

    // clock/reset
    reset = 1'b1; e_level_start = 1'b0; e_color_mode = 2'd0; e_pause_qb = 1'b0;
    position_qb = '0; done_move_qb = 1'b0;
    repeat (3) @(negedge CLK_33);
    check("reset_color", 64'(e_color_state), 64'd0);
    check("reset_cubes_left", 64'(cubes_left), 64'd28);
    check("reset_pulses", 64'({score_pulse, off_map, bad_pos}), 64'd0);
    check("reset_level_done", 64'(level_done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // done_move already high at reset release must not land
    done_move_qb = 1'b1; position_qb = 28'h0000004;
    @(negedge CLK_33); reset = 1'b0;
    any_busy = 1'b0;
    repeat (4) begin
      @(negedge CLK_33);
      any_busy = any_busy | busy;
    end
    check("no_landing_after_reset", 64'(any_busy), 64'd0);
    done_move_qb = 1'b0;
    @(negedge CLK_33);

    // table-driven landings
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].start) start_level(vecs[i].mode);
      exp_q.push_back(W'(vecs[i].exp));
      land(vecs[i].pos, vecs[i].pause);
    end

    // full level in mode 0, then a landing in WIN, then a new level
    start_level(2'd0);
    for (int i = 0; i < N; i++) begin
      mask = (29'd1 << (i + 1)) - 29'd1;
      exp_q.push_back(W'(mk(1, 0, 0, 4'b1110, mask[N-1:0], C'(N - 1 - i), (i == N - 1))));
      land(28'd1 << i, 1'b0);
    end
    exp_q.push_back(W'(mk(0, 0, 0, 4'b0000, 28'hFFFFFFF, 5'd0, 1)));
    land(28'h0000001, 1'b0);
    start_level(2'd0);
    check("new_level_color", 64'(e_color_state), 64'd0);
    check("new_level_left", 64'(cubes_left), 64'd28);
    check("new_level_done", 64'(level_done), 64'd0);

    // level start in the same cycle as a done_move edge
    @(negedge CLK_33);
    position_qb = 28'h0000002; done_move_qb = 1'b1; e_level_start = 1'b1; e_color_mode = 2'd0;
    @(negedge CLK_33);
    e_level_start = 1'b0; done_move_qb = 1'b0;
    any_busy = busy; any_score = score_pulse;
    repeat (3) begin
      @(negedge CLK_33);
      any_busy = any_busy | busy; any_score = any_score | score_pulse;
    end
    check("collide_busy", 64'(any_busy), 64'd0);
    check("collide_score", 64'(any_score), 64'd0);
    check("collide_color", 64'(e_color_state), 64'd0);

    // level start held during UPDATE
    @(negedge CLK_33);
    position_qb = 28'h0000004; done_move_qb = 1'b1;
    @(negedge CLK_33);
    done_move_qb = 1'b0;
    @(posedge CLK_33); #1;
    e_level_start = 1'b1;
    #1;
    check("update_start_score", 64'(score_pulse), 64'd0);
    check("update_start_busy_mid", 64'(busy), 64'd1);
    @(posedge CLK_33); #1;
    e_level_start = 1'b0;
    @(negedge CLK_33);
    check("update_start_busy", 64'(busy), 64'd0);
    check("update_start_color", 64'(e_color_state), 64'd0);
    check("update_start_left", 64'(cubes_left), 64'd28);
    @(negedge CLK_33);
    check("update_start_color_late", 64'(e_color_state), 64'd0);

    // asynchronous reset during COUNT
    @(negedge CLK_33);
    position_qb = 28'h0000010; done_move_qb = 1'b1;
    @(negedge CLK_33);
    done_move_qb = 1'b0;
    @(negedge CLK_33);
    @(negedge CLK_33);
    check("count_color_before_reset", 64'(e_color_state), 64'h10);
    check("count_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset_color", 64'(e_color_state), 64'd0);
    check("async_reset_left", 64'(cubes_left), 64'd28);
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_flags", 64'({score_pulse, off_map, bad_pos, level_done}), 64'd0);
    @(negedge CLK_33);
    reset = 1'b0;
    @(negedge CLK_33);
    check("post_reset_left", 64'(cubes_left), 64'd28);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
